// File: rtl/iq_interleave.sv
// iq_interleave: serializes (I,Q) drive pairs onto one bus with an iq strobe and de-interleaves the returned field stream
// Ports: clk/rst_n (async active-low); en run enable; in_valid/in_ready/in_i/in_q drive pair handshake;
// iq phase strobe (1 = I slot); drive multiplexed drive; field multiplexed plant return;
// out_valid/out_i/out_q de-interleaved field pair; underrun saturating count of empty I slots.
module iq_interleave #(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_i,
  input  logic [DW-1:0] in_q,
  output logic          iq,
  output logic [DW-1:0] drive,
  input  logic [DW-1:0] field,
  output logic          out_valid,
  output logic [DW-1:0] out_i,
  output logic [DW-1:0] out_q,
  output logic [15:0]   underrun
);
  typedef enum logic [1:0] {IDLE, ISLOT, QSLOT} state_t;
  state_t state, state_nx;
  logic [2*DW-1:0] mem [2];
  logic [2*DW-1:0] head;
  logic [DW-1:0] q_hold, i_hold;
  logic [1:0] cnt;
  logic wp, rp, push, pop, has;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == ISLOT ? QSLOT : en ? ISLOT : IDLE;
  end
  assign has      = cnt != 2'd0;
  assign head     = mem[rp];
  assign in_ready = !cnt[1];
  assign push     = in_valid && in_ready;
  assign pop      = state_nx == ISLOT && has;
  assign iq       = state == ISLOT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem[0]    <= '0;
      mem[1]    <= '0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      cnt       <= 2'd0;
      drive     <= '0;
      q_hold    <= '0;
      i_hold    <= '0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      underrun  <= '0;
    end else begin
      state <= state_nx;
      if (push) begin
        mem[wp] <= {in_i, in_q};
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt   <= cnt + {1'b0, push} - {1'b0, pop};
      drive <= state_nx == ISLOT ? (has ? head[2*DW-1:DW] : '0) : state_nx == QSLOT ? q_hold : '0;
      if (state_nx == ISLOT) begin
        q_hold <= has ? head[DW-1:0] : '0;
        if (!has && underrun != 16'hFFFF) underrun <= underrun + 16'd1;
      end
      if (state == ISLOT) i_hold <= field;
      out_valid <= state == QSLOT;
      if (state == QSLOT) begin
        out_i <= i_hold;
        out_q <= field;
      end
    end
  end
endmodule
